bin2bcd_seq: RTL

- Sequential double-dabble binary-to-BCD converter.
- Sits directly downstream of the 8x8 sequential multiplier: it captures the 16-bit product when the multiplier's done pulses.
- Emits five packed BCD digits to the 7-segment display driver.
- Performs one shift per clock, so it needs no combinational divide chain.

---
 rtl/bin2bcd_pkg.sv | 34 +++
 rtl/bin2bcd_seq_digit_adj.sv | 17 +
 rtl/bin2bcd_seq.sv | 129 ++++++++++++
 3 files changed

// File: rtl/bin2bcd_pkg.sv
// Shared types and constants for the sequential double-dabble converter.
// Optional build macro: BIN2BCD_BLANK_EN (leading-zero blank mask).
package bin2bcd_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    typedef logic [3:0] bcd_digit_t;

    localparam bcd_digit_t BCD_ADJ_THRESH = 4'd5;
    localparam bcd_digit_t BCD_ADJ_ADD    = 4'd3;

    // Decimal digits needed to show the largest WIDTH-bit value.
    function automatic int bcd_digits(input int width);
        longint unsigned v;
        int              n;
        v = (64'd1 << width) - 64'd1;
        n = 0;
        for (int i = 0; i < 20; i++) begin
            if (v != 0) begin
                v = v / 64'd10;
                n = n + 1;
            end
        end
        if (n == 0) begin
            n = 1;
        end
        return n;
    endfunction

endpackage

// File: rtl/bin2bcd_seq_digit_adj.sv
// Double-dabble correction cell: a digit of 5..9 gets +3 before the shift.
// Purely combinational; 5..9 + 3 stays within 4 bits.
module bcd_digit_adj
    import bin2bcd_pkg::*;
(
    input  bcd_digit_t din,
    output bcd_digit_t dout
);

    always_comb begin
        dout = din;
        if (din >= BCD_ADJ_THRESH) begin
            dout = din + BCD_ADJ_ADD;
        end
    end

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter, one double-dabble shift per clock.
// Optional build macro: BIN2BCD_BLANK_EN (registered leading-zero blank mask).
module bin2bcd_seq
    import bin2bcd_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int DIGITS = bcd_digits(WIDTH)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [WIDTH-1:0]    bin_in,
    input  logic                load,
    output logic                busy,
    output logic [4*DIGITS-1:0] bcd_out,
    output logic                bcd_valid,
    output logic [DIGITS-1:0]   blank
);

    localparam int BW = 4 * DIGITS;
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  bin_q, bin_d;
    logic [BW-1:0]     scr_q, scr_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [BW-1:0]     bcd_q, bcd_d;
    logic              valid_q, valid_d;
    logic [BW-1:0]     scr_adj;

    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_digit_adj u_adj (
            .din  (scr_q[4*g +: 4]),
            .dout (scr_adj[4*g +: 4])
        );
    end

    always_comb begin
        state_d = state_q;
        bin_d   = bin_q;
        scr_d   = scr_q;
        cnt_d   = cnt_q;
        bcd_d   = bcd_q;
        valid_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (load) begin
                    state_d = SHIFT;
                    bin_d   = bin_in;
                    scr_d   = '0;
                    cnt_d   = '0;
                end
            end
            SHIFT: begin
                {scr_d, bin_d} = {scr_adj, bin_q} << 1;
                cnt_d          = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                bcd_d   = scr_q;
                valid_d = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            bin_q   <= '0;
            scr_q   <= '0;
            cnt_q   <= '0;
            bcd_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            bin_q   <= bin_d;
            scr_q   <= scr_d;
            cnt_q   <= cnt_d;
            bcd_q   <= bcd_d;
            valid_q <= valid_d;
        end
    end

`ifdef BIN2BCD_BLANK_EN
    logic [DIGITS-1:0] blank_q, blank_d;
    logic [DIGITS-1:0] lz;
    logic              acc;

    // Digit i blanks only if it and every higher digit are zero; units never.
    always_comb begin
        lz  = '0;
        acc = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            acc   = acc & (scr_q[4*i +: 4] == 4'd0);
            lz[i] = acc;
        end
    end

    always_comb begin
        blank_d = blank_q;
        if (state_q == DONE) begin
            blank_d = lz;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            blank_q <= '0;
        end else begin
            blank_q <= blank_d;
        end
    end

    assign blank = blank_q;
`else
    assign blank = '0;
`endif

    assign busy      = (state_q != IDLE);
    assign bcd_out   = bcd_q;
    assign bcd_valid = valid_q;

endmodule
